fir_sample_pacer: RTL and testbench

Input pacing stage placed directly upstream of the 3-tap shared-multiplier FIR (y = x1·r1 + x2·r2 + x3·r3). It accepts signed 8-bit samples over a valid/ready stream and buffers them in a small FIFO. It re-issues each sample as a single-cycle `x`/`x_stb` pulse, spaced at least `GAP` cycles apart. This guarantees the FIR's 4-cycle multiply/accumulate sequence is never overrun.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_sample_fifo.sv | 49 ++++
 rtl/fir_sample_pacer.sv | 101 ++++++++++
 tb/tb_fir_sample_pacer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the 3-tap FIR datapath and its input pacer.
// The downstream FIR reuses the coefficients; fir_mac is its reference arithmetic.
package fir_pkg;

  typedef logic signed [7:0] sample_t;

  // Depth of the FIR multiply/accumulate pipeline; the pacer gap may not go below it.
  localparam int GAP_MIN = 4;

  localparam sample_t COEF_R1 = 8'sd2;
  localparam sample_t COEF_R2 = -8'sd4;
  localparam sample_t COEF_R3 = 8'sd7;

  typedef enum logic {
    PACER_READY = 1'b0,
    PACER_HOLD  = 1'b1
  } pacer_state_t;

  function automatic int fir_mac(input int x1, input int x2, input int x3);
    return x1 * int'(COEF_R1) + x2 * int'(COEF_R2) + x3 * int'(COEF_R3);
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Small sample FIFO for the pacer: extra-MSB pointers, combinational head read.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 rd_en,
  output logic signed [DW-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic signed [DW-1:0] mem [DEPTH];
  logic                 do_wr;
  logic                 do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_sample_pacer.sv
// Paces buffered samples into the FIR as single-cycle strobes at least GAP cycles apart.
// Optional back-pressure counter bp_cnt is built when FIR_PACER_STATS_EN is defined.
module fir_sample_pacer
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 10
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [DW-1:0] x,
  output logic                 x_stb
`ifdef FIR_PACER_STATS_EN
  ,
  output logic [15:0]          bp_cnt
`endif
);

  localparam int GAP_EFF = (GAP < GAP_MIN) ? GAP_MIN : GAP;
  localparam int CW      = $clog2(GAP_EFF);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_EFF - 1);
  localparam logic [CW-1:0] GAP_ONE  = CW'(1);

  pacer_state_t         state;
  pacer_state_t         next_state;
  logic [CW-1:0]        gap_cnt;
  logic [CW-1:0]        next_gap;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic signed [DW-1:0] head;

  assign s_ready = rst_n && !fifo_full;
  assign push    = s_valid && s_ready;

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Leaving HOLD when the count reads 1 puts the next pop exactly GAP edges after the last.
  always_comb begin
    next_state = state;
    next_gap   = gap_cnt;
    pop        = 1'b0;
    case (state)
      PACER_READY: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_gap   = GAP_LOAD;
          next_state = PACER_HOLD;
        end
      end
      PACER_HOLD: begin
        next_gap = gap_cnt - GAP_ONE;
        if (gap_cnt == GAP_ONE) next_state = PACER_READY;
      end
      default: next_state = PACER_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PACER_READY;
      gap_cnt <= '0;
      x       <= '0;
      x_stb   <= 1'b0;
    end else begin
      state   <= next_state;
      gap_cnt <= next_gap;
      x_stb   <= pop;
      if (pop) x <= head;
    end
  end

`ifdef FIR_PACER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_cnt <= '0;
    end else if (s_valid && !s_ready && (bp_cnt != 16'hFFFF)) begin
      bp_cnt <= bp_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed bench for fir_sample_pacer: expected strobes are queued when samples are driven
// and matched (value and edge) as the DUT strobes them.
module tb_fir_sample_pacer;
  import fir_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 10;

  typedef struct {
    logic signed [7:0] val;
    int                at_edge;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] x;
  logic                 x_stb;
`ifdef FIR_PACER_STATS_EN
  logic [15:0]          bp_cnt;
`endif

  exp_t              sb[$];
  int                vectors     = 0;
  int                miscompares = 0;
  int                edge_cnt    = 0;
  int                last_strobe = -1000;
  int                seen_edge   = -1;
  logic signed [7:0] exp_hold    = 8'sd0;
  int                fx1 = 0, fx2 = 0, fx3 = 0;
  logic signed [7:0] burst_val [8];
  int                burst_off [8];
  int                acc_edge;
  int                start_edge;

  fir_sample_pacer #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .x       (x),
    .x_stb   (x_stb)
`ifdef FIR_PACER_STATS_EN
    ,
    .bp_cnt  (bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [7:0] d, input logic v);
    s_data  = d;
    s_valid = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference pacing: a strobe follows acceptance by one edge, but never sooner than GAP after the last.
  function automatic void pushExpected(input logic signed [7:0] v, input int acc);
    int s;
    exp_t e;
    s = acc + 1;
    if (last_strobe + GAP > s) s = last_strobe + GAP;
    last_strobe = s;
    e.val       = v;
    e.at_edge   = s;
    sb.push_back(e);
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("drain_within_budget", sb.size(), 0);
  endtask

  // Holds s_valid high through n samples; burst_off gives each acceptance edge relative to the first.
  task automatic runBurst(input int n);
    int e;
    e = edge_cnt + 1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(burst_val[i], 1'b1);
      while (edge_cnt + 1 < e + burst_off[i]) begin
        checkOutput("ready_low_while_full", s_ready, 0);
        tick(1);
      end
      checkOutput("ready_at_accept", s_ready, 1);
      pushExpected(burst_val[i], edge_cnt + 1);
      tick(1);
    end
    applyStimulus(8'sd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (x_stb === 1'b1) begin
        exp_t e;
        seen_edge = edge_cnt;
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("[TB] FAIL unexpected_strobe: observed strobe x=%0d at edge %0d, expected none",
                 x, edge_cnt);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("strobe_data", x, e.val);
          checkOutput("strobe_edge", edge_cnt, e.at_edge);
          exp_hold = e.val;
        end
        fx3 = fx2;
        fx2 = fx1;
        fx1 = int'(x);
      end else begin
        checkOutput("x_held", x, exp_hold);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'sd5, 1'b1);
    tick(3);
    checkOutput("reset_x", x, 0);
    checkOutput("reset_x_stb", x_stb, 0);
    checkOutput("reset_s_ready", s_ready, 0);
`ifdef FIR_PACER_STATS_EN
    checkOutput("reset_bp_cnt", bp_cnt, 0);
`endif

    rst_n = 1'b1;
    applyStimulus(8'sd0, 1'b0);
    tick(1);
    checkOutput("ready_after_reset", s_ready, 1);

    // Single sample into an idle pacer
    applyStimulus(-8'sd3, 1'b1);
    acc_edge = edge_cnt + 1;
    pushExpected(-8'sd3, acc_edge);
    tick(1);
    applyStimulus(8'sd0, 1'b0);
    waitDrain(20);
    checkOutput("single_latency", seen_edge - acc_edge, 1);
    checkOutput("fir_y_single", fir_mac(fx1, fx2, fx3), -6);
    tick(12);

    // Six-sample burst against a four-deep FIFO
    burst_val[0] = -8'sd3; burst_val[1] = 8'sd9; burst_val[2] = 8'sd4;
    burst_val[3] = -8'sd8; burst_val[4] = 8'sd2; burst_val[5] = 8'sd5;
    burst_off[0] = 0; burst_off[1] = 1; burst_off[2] = 2;
    burst_off[3] = 3; burst_off[4] = 4; burst_off[5] = 12;
    runBurst(6);
`ifdef FIR_PACER_STATS_EN
    checkOutput("bp_cnt_burst", bp_cnt, 7);
`endif
    waitDrain(80);

    // Late arrival long after the gap has expired
    while (edge_cnt < last_strobe + 24) tick(1);
    applyStimulus(8'sd9, 1'b1);
    checkOutput("late_ready", s_ready, 1);
    acc_edge = edge_cnt + 1;
    pushExpected(8'sd9, acc_edge);
    tick(1);
    applyStimulus(8'sd0, 1'b0);
    waitDrain(10);
    checkOutput("late_latency", seen_edge - acc_edge, 1);
    tick(12);

    // Asynchronous reset between the 2nd and 3rd strobes of a burst
    burst_val[0] = 8'sd7;  burst_val[1] = -8'sd2;
    burst_val[2] = 8'sd11; burst_val[3] = -8'sd5;
    burst_off[0] = 0; burst_off[1] = 1; burst_off[2] = 2; burst_off[3] = 3;
    start_edge = edge_cnt + 1;
    runBurst(4);
    while (edge_cnt < start_edge + 14) tick(1);
    rst_n = 1'b0;
    sb.delete();
    exp_hold    = 8'sd0;
    last_strobe = -1000;
    #1;
    checkOutput("midreset_x", x, 0);
    checkOutput("midreset_x_stb", x_stb, 0);
    checkOutput("midreset_s_ready", s_ready, 0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    checkOutput("post_reset_quiet_x", x, 0);
    checkOutput("post_reset_quiet_stb", x_stb, 0);

    applyStimulus(8'sd4, 1'b1);
    acc_edge = edge_cnt + 1;
    pushExpected(8'sd4, acc_edge);
    tick(1);
    applyStimulus(8'sd0, 1'b0);
    waitDrain(10);
    checkOutput("fresh_latency", seen_edge - acc_edge, 1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
